// File: rtl/gain_ramp_stage.sv
// gain_ramp_stage: 2-stage gain/saturate pipeline with valid/ready handshake.
// Define GAIN_RAMP_EN for one code step per accepted sample; otherwise the gain jumps to target.
module gain_ramp_stage #(
  parameter int width_p = 24,
  parameter int gain_width_p = 5
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [gain_width_p-1:0] gain_i,
  input  logic                    mute_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [width_p-1:0]      data_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [width_p-1:0]      data_o
);
  localparam int pw = width_p + gain_width_p + 1;
  localparam logic signed [pw-1:0] s_max = {{(pw-width_p+1){1'b0}}, {(width_p-1){1'b1}}};
  localparam logic signed [pw-1:0] s_min = {{(pw-width_p+1){1'b1}}, {(width_p-1){1'b0}}};
  logic [gain_width_p-1:0] g, g_nxt, t;
  logic signed [pw-1:0] p1, s;
  logic [width_p-1:0] sat;
  logic v1, v2, adv, acc;
  assign adv = !v2 || ready_i;
  assign ready_o = adv;
  assign valid_o = v2;
  assign acc = valid_i && adv;
  assign t = mute_i ? '0 : gain_i;
`ifdef GAIN_RAMP_EN
  assign g_nxt = (g < t) ? g + 1'b1 : (g > t) ? g - 1'b1 : g;
`else
  assign g_nxt = t;
`endif
  // floor shift by the unity exponent, then clamp to the sample range
  assign s = p1 >>> (gain_width_p - 1);
  assign sat = (s > s_max) ? {1'b0, {(width_p-1){1'b1}}} :
               (s < s_min) ? {1'b1, {(width_p-1){1'b0}}} : s[width_p-1:0];
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      g      <= '0;
      p1     <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      data_o <= '0;
    end else if (adv) begin
      p1     <= pw'($signed(data_i)) * pw'($signed({1'b0, g}));
      v1     <= acc;
      v2     <= v1;
      data_o <= sat;
      if (acc) g <= g_nxt;
    end
endmodule

// File: tb/tb_gain_ramp_stage.sv
// tb_gain_ramp_stage: directed checks of gain_ramp_stage; expectations follow GAIN_RAMP_EN.
module tb_gain_ramp_stage;
`ifdef GAIN_RAMP_EN
  localparam bit ramp = 1'b1;
`else
  localparam bit ramp = 1'b0;
`endif
  logic clk_i = 1'b0, reset_ni = 1'b0, mute_i = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
  logic [4:0] gain_i = 5'd16;
  logic [23:0] data_i = '0, data_o;
  logic ready_o, valid_o;
  logic [23:0] got[$];
  int n_checks = 0, n_fail = 0;

  gain_ramp_stage dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .gain_i(gain_i), .mute_i(mute_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o)
  );

  always #5 clk_i = ~clk_i;

  // inputs change 1 time unit after posedge, so negedge sees the values the next edge uses
  always @(negedge clk_i) if (reset_ni && valid_o && ready_i) got.push_back(data_o);

  task automatic stream(input logic [23:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      data_i = d;
      valid_i = 1'b1;
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic check_q(input string name, input logic [23:0] exp[$]);
    n_checks++;
    if (got.size() !== exp.size()) begin
      n_fail++;
      $display("FAIL %s count: got %0d required %0d", name, got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %h required %h", name, i, got[i], exp[i]);
      end
    end
    got.delete();
  endtask

  task automatic test_reset;
    n_checks++;
    if ({valid_o, ready_o, data_o, dut.g} !== {1'b0, 1'b1, 24'h0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset: got v=%b r=%b d=%h g=%0d required v=0 r=1 d=000000 g=0",
               valid_o, ready_o, data_o, dut.g);
    end
  endtask

  task automatic test_fade_in;
    logic [23:0] exp[$];
    gain_i = 5'd16;
    stream(24'h100000, 20);
    for (int i = 0; i < 20; i++)
      exp.push_back(ramp ? 24'((i < 16 ? i : 16) * 24'h010000) : (i == 0 ? 24'h0 : 24'h100000));
    check_q("fade_in", exp);
  endtask

  task automatic test_saturation;
    logic [23:0] exp[$];
    gain_i = 5'd31;
    stream(24'h0, 32);
    got.delete();
    data_i = 24'h400000; valid_i = 1'b1; @(posedge clk_i); #1;
    data_i = 24'h600000; @(posedge clk_i); #1;
    data_i = 24'hA00000; @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    exp = '{24'h7C0000, 24'h7FFFFF, 24'h800000};
    check_q("saturation", exp);
    gain_i = 5'd1;
    stream(24'h0, 32);
    got.delete();
    stream(24'hFFFFFF, 2);
    exp = '{24'hFFFFFF, 24'hFFFFFF};
    check_q("floor_shift", exp);
  endtask

  task automatic test_backpressure;
    logic [23:0] exp[$];
    logic [23:0] held;
    int next = 0;
    gain_i = 5'd16;
    stream(24'h0, 20);
    got.delete();
    for (int c = 0; next < 10 && c < 40; c++) begin
      ready_i = !(c >= 4 && c < 9);
      data_i = 24'(next * 3 + 5);
      valid_i = 1'b1;
      #1;
      if (c == 4) held = data_o;
      if (!ready_i) begin
        n_checks++;
        if ({ready_o, valid_o, data_o, dut.g} !== {1'b0, 1'b1, held, 5'd16}) begin
          n_fail++;
          $display("FAIL stall c=%0d: got r=%b v=%b d=%h g=%0d required r=0 v=1 d=%h g=16",
                   c, ready_o, valid_o, data_o, dut.g, held);
        end
      end
      if (ready_o) next++;
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    for (int i = 0; i < 10; i++) exp.push_back(24'(i * 3 + 5));
    check_q("backpressure", exp);
  endtask

  task automatic test_mute;
    logic [23:0] exp[$];
    gain_i = 5'd16;
    stream(24'h100000, 20);
    got.delete();
    mute_i = 1'b1;
    stream(24'h100000, 20);
    for (int i = 0; i < 20; i++)
      exp.push_back(ramp ? 24'((i < 16 ? 16 - i : 0) * 24'h010000) : (i == 0 ? 24'h100000 : 24'h0));
    check_q("mute_down", exp);
    exp.delete();
    mute_i = 1'b0;
    stream(24'h100000, 20);
    for (int i = 0; i < 20; i++)
      exp.push_back(ramp ? 24'((i < 16 ? i : 16) * 24'h010000) : (i == 0 ? 24'h0 : 24'h100000));
    check_q("mute_up", exp);
  endtask

  task automatic test_async_reset;
    logic [23:0] exp[$];
    gain_i = 5'd16;
    data_i = 24'h100000;
    valid_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #3;
    valid_i = 1'b0;
    reset_ni = 1'b0;
    #1;
    n_checks++;
    if ({valid_o, ready_o, data_o} !== {1'b0, 1'b1, 24'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b r=%b d=%h required v=0 r=1 d=000000",
               valid_o, ready_o, data_o);
    end
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    got.delete();
    stream(24'h100000, 3);
    exp = '{24'h0, ramp ? 24'h010000 : 24'h100000, ramp ? 24'h020000 : 24'h100000};
    check_q("after_reset", exp);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    test_reset();
    reset_ni = 1'b1;
    test_fade_in();
    test_saturation();
    test_backpressure();
    test_mute();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gain_ramp_stage.md
# gain_ramp_stage

Streaming volume stage between the waveform select mux and the I2S transmitter. It scales each signed audio sample by a gain taken from the rotary-encoder position. The applied gain ramps one step per sample toward its target, so encoder turns and mute produce no zipper noise. A valid/ready handshake on both sides, a 2-stage pipeline and output saturation keep the DAC feed clean.

## Interface
- `width_p`, 24, sample width in bits (two's complement).
- `gain_width_p`, 5, gain code width. The gain is `code / 2^(gain_width_p-1)`, so code 16 is unity and the range is 0..1.9375.
- `clk_i` input 1: sample-domain clock.
- `reset_ni` input 1: reset, **asynchronous, active-low**. There is one clock, `clk_i`. There is no other reset.
- `gain_i` input `gain_width_p`: target gain code, e.g. encoder position.
- `mute_i` input 1: when high, the target is forced to 0.
- `valid_i` input 1: `data_i` is valid.
- `ready_o` output 1: the stage accepts `data_i` this cycle.
- `data_i` input `width_p`: signed input sample.
- `valid_o` output 1: `data_o` is valid.
- `ready_i` input 1: the downstream stage accepts `data_o`.
- `data_o` output `width_p`: signed scaled sample.

## Operation
- **Internal state:**
  - Current gain register `g` (`gain_width_p` bits).
  - Stage-1 register: product plus valid bit `v1`.
  - Stage-2 register: saturated result plus valid bit `v2`.
- **Pipeline advance:** `adv = !v2 | ready_i`. `ready_o = adv`. The entire pipeline advances only when `adv` is high.
- **Accept:** `valid_i & ready_o`.
- **On advance, stage 1:**
  - `p1 <= $signed(data_i) * $signed({1'b0, g})`. The product is `width_p + gain_width_p + 1` bits.
  - `v1 <= accept`.
- **On advance, stage 2:**
  - `s = p1 >>> (gain_width_p - 1)`. This is an arithmetic shift (floor).
  - If `s > 2^(width_p-1) - 1`, the result is `0x7FFFFF`.
  - If `s < -2^(width_p-1)`, the result is `0x800000`.
  - Otherwise the result is `s` truncated to `width_p` bits.
  - `v2 <= v1`.
- **Gain ramp (per accepted sample only):**
  - Target `t = mute_i ? 0 : gain_i`, sampled on the accept cycle.
  - The sample accepted on a given cycle uses the old `g`.
  - On that same edge: `g <= g+1` if `g < t`, `g <= g-1` if `g > t`, otherwise `g` holds.
  - `g` never moves without an accept. With no input traffic the gain is frozen.
- **Stall:** while `v2 & !ready_i`:
  - `data_o` and `valid_o` hold stable.
  - `ready_o` is 0.
  - Stage 1, stage 2 and `g` all hold.
- **Changes to `gain_i` / `mute_i`:** a change in any cycle takes effect only at the next accept. Changing the target mid-ramp redirects the ramp from the current `g`.
- **Bounds:** `g` saturates naturally at 0 and `2^gain_width_p - 1`, because the target is always within range.

## Timing
- **Reset values:** `g = 0`, `v1 = 0`, `v2 = 0`, `valid_o = 0`, `data_o = 0`, `ready_o = 1`. Since `g` resets to 0, the output fades in after reset.
- **Reset asserted mid-operation:** in-flight samples are discarded immediately (async). After deassertion, the output resumes from `g = 0`.
- **Latency:** a sample accepted at edge N appears on `data_o` with `valid_o = 1` after edge N+1 (visible in cycle N+2). This is 2 cycles with no stall.
- **Throughput:** one sample per cycle when `ready_i` is held high.
- **Ramp duration:** 0 to unity takes 16 accepted samples; 0 to 31 takes 31. At 48 kHz a full ramp is under 1 ms.
- **Simultaneous accept and stage-2 drain:** allowed when `ready_i = 1`. No bubble is inserted.

## Configuration
- **`GAIN_RAMP_EN` defined:** the ramp behaves as described above, one code step per accepted sample.
- **`GAIN_RAMP_EN` undefined:**
  - On each accept, `g <= t` directly (a step change). The accepted sample still uses the old `g`.
  - After reset, `g = 0`, so the first accepted sample outputs 0. Every following sample uses the full target.
  - Mute takes effect on the second sample after it asserts.

## Test plan
- **Fade-in after reset:** reset, `gain_i = 16`, constant `data_i = 0x100000` with `valid_i`/`ready_i` high. Required outputs: `0x000000, 0x010000, 0x020000, …, 0x0F0000`, then `0x100000` for every sample from the 17th onward.
- **Positive saturation:** after `g` has settled at 31:
  - `data_i = 0x400000` gives `0x7C0000`.
  - `data_i = 0x600000` gives `0x7FFFFF`.
- **Negative saturation and floor shift:** with `g = 31`, `data_i = 0xA00000` gives `0x800000`. With `g = 1`, `data_i = 0xFFFFFF` gives `0xFFFFFF` (floor, not 0).
- **Backpressure:** drop `ready_i` for 5 cycles while `valid_o = 1`. Required:
  - `data_o` is stable and `ready_o = 0` throughout.
  - `g` is unchanged.
  - After `ready_i` returns, no samples are lost or duplicated, and ordering is preserved.
- **Mute:** with `g = 16` and input `0x100000`, assert `mute_i`. Outputs step down by `0x010000` per sample to 0 and then stay at 0. Deasserting mute ramps back up.
- **Async reset mid-stream:** assert `reset_ni = 0` between edges while `v1` and `v2` are set. `valid_o` drops immediately. After release, the first output is 0 (`g = 0`).
- **Each scenario is repeated with `GAIN_RAMP_EN` undefined.** In the fade-in case the required outputs become `0x000000` followed by `0x100000`.
